// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the byte-lane MIPS data memory.
//   - Access size encodings carried on the 'size' port
//   - Sequencer state type (post-reset clear, then normal operation)
//   - is_aligned(): decides whether a size/offset pair is a legal access
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } mem_state_t;

    // Bytes may sit anywhere, halves need an even address, words need a
    // word-aligned address, and the reserved size code never succeeds.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~offset[0];
            SZ_WORD: ok = (offset == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Combinational big-endian lane steering shared by the store and load paths.
// Byte offset 0 is the most significant lane (bits [31:24]).
//
// Ports:
//   i_isLoad   : 1 = o_data is the extracted/extended load value,
//                0 = o_data is the store word replicated into every lane
//   i_size     : access size (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_ILL)
//   i_offset   : byte offset inside the word
//   i_unsigned : zero-extend byte/half loads instead of sign-extending
//   i_data     : store data (right-justified) or the memory word being loaded
//   o_laneEn   : one bit per byte lane touched, bit 3 = bits [31:24];
//                all zero for a misaligned or illegal access
//   o_data     : steered data word
// ---------------------------------------------------------------------------
module mem_lane_align
    import mem_pkg::*;
(
    input  logic        i_isLoad,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_unsigned,
    input  logic [31:0] i_data,
    output logic [3:0]  o_laneEn,
    output logic [31:0] o_data
);

    logic [3:0]  w_lanes;
    logic [31:0] w_storeWord;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_loadWord;
    logic        w_extBit;

    // A faulting access enables no lanes, so the array is never touched.
    always_comb begin
        w_lanes = 4'b0000;
        if (is_aligned(i_size, i_offset)) begin
            case (i_size)
                SZ_BYTE: w_lanes = 4'b1000 >> i_offset;
                SZ_HALF: w_lanes = i_offset[1] ? 4'b0011 : 4'b1100;
                SZ_WORD: w_lanes = 4'b1111;
                default: w_lanes = 4'b0000;
            endcase
        end
    end

    // Replicating the right-justified store data across all lanes lets the
    // lane enables alone pick the destination, independent of offset.
    always_comb begin
        case (i_size)
            SZ_BYTE: w_storeWord = {4{i_data[7:0]}};
            SZ_HALF: w_storeWord = {2{i_data[15:0]}};
            default: w_storeWord = i_data;
        endcase
    end

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_data[31:24];
            2'd1:    w_byte = i_data[23:16];
            2'd2:    w_byte = i_data[15:8];
            default: w_byte = i_data[7:0];
        endcase
        w_half = i_offset[1] ? i_data[15:0] : i_data[31:16];
    end

    always_comb begin
        w_extBit   = 1'b0;
        w_loadWord = i_data;
        case (i_size)
            SZ_BYTE: begin
                w_extBit   = ~i_unsigned & w_byte[7];
                w_loadWord = {{24{w_extBit}}, w_byte};
            end
            SZ_HALF: begin
                w_extBit   = ~i_unsigned & w_half[15];
                w_loadWord = {{16{w_extBit}}, w_half};
            end
            default: w_loadWord = i_data;
        endcase
    end

    assign o_laneEn = w_lanes;
    assign o_data   = i_isLoad ? w_loadWord : w_storeWord;

endmodule

// File: rtl/data_memory_bytelane.sv
// ---------------------------------------------------------------------------
// data_memory_bytelane
// MEM-stage data memory with byte-addressed, size-aware loads and stores,
// alignment fault reporting and an optional post-reset clear sequence.
//
// Parameters:
//   ADDR_W         : byte address width, array holds 2**(ADDR_W-2) words
//   CLEAR_ON_RESET : 1 = zero every word after reset before raising ready
//
// Ports:
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   memread      : load request
//   memwrite     : store request
//   address      : byte address ([ADDR_W-1:2] word, [1:0] byte offset)
//   size         : 00 byte, 01 half, 10 word, 11 illegal
//   unsigned_ld  : zero-extend byte/half loads
//   write_data   : right-justified store data
//   read_data    : extended load result, valid the cycle after the request
//   ready        : block accepts accesses
//   misalign     : one-cycle fault flag for the preceding access
// ---------------------------------------------------------------------------
module data_memory_bytelane
    import mem_pkg::*;
#(
    parameter int ADDR_W         = 15,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] address,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic              misalign
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int WORDS = 2 ** IDX_W;

    logic [31:0]      r_mem [WORDS];
    mem_state_t       r_state;
    mem_state_t       w_nextState;
    logic [IDX_W-1:0] r_clearCount;

    logic [31:0]      r_ldWord;
    logic [1:0]       r_ldSize;
    logic [1:0]       r_ldOffset;
    logic             r_ldUnsigned;
    logic             r_misalign;

    logic [IDX_W-1:0] w_wordIdx;
    logic [1:0]       w_offset;
    logic             w_run;
    logic             w_clearing;
    logic             w_fault;
    logic             w_doRead;
    logic             w_doWrite;
    logic [3:0]       w_stLanes;
    logic [31:0]      w_stData;
    logic [31:0]      w_ldData;
    logic [3:0]       w_unusedLdLanes;
    logic [IDX_W-1:0] w_wrIdx;
    logic [3:0]       w_wrLanes;
    logic [31:0]      w_wrData;

    assign w_wordIdx = address[ADDR_W-1:2];
    assign w_offset  = address[1:0];

    // Store side: steer right-justified write data into the addressed lanes.
    mem_lane_align u_storeAlign (
        .i_isLoad   (1'b0),
        .i_size     (size),
        .i_offset   (w_offset),
        .i_unsigned (1'b0),
        .i_data     (write_data),
        .o_laneEn   (w_stLanes),
        .o_data     (w_stData)
    );

    // Load side: works on the word captured at the request edge together
    // with the request's own size/offset/sign, so it lines up with the
    // synchronous array read.
    mem_lane_align u_loadAlign (
        .i_isLoad   (1'b1),
        .i_size     (r_ldSize),
        .i_offset   (r_ldOffset),
        .i_unsigned (r_ldUnsigned),
        .i_data     (r_ldWord),
        .o_laneEn   (w_unusedLdLanes),
        .o_data     (w_ldData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Clear runs until the last word index has been written; the counter
    // then wraps to zero on the same edge the state moves to RUN.
    always_comb begin
        w_nextState = r_state;
        w_run       = 1'b0;
        w_clearing  = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clearing = ~rst;
                if (r_clearCount == {IDX_W{1'b1}}) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run = ~rst;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clearCount <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clearCount <= r_clearCount + IDX_W'(1);
        end
    end

    assign w_fault   = w_run & (memread | memwrite) & ~is_aligned(size, w_offset);
    assign w_doRead  = w_run & memread & ~w_fault;
    assign w_doWrite = w_run & memwrite & ~w_fault;

    // Single write port shared by the clear sequencer and pipeline stores.
    always_comb begin
        w_wrIdx   = w_wordIdx;
        w_wrData  = w_stData;
        w_wrLanes = 4'b0000;
        if (w_clearing) begin
            w_wrIdx   = r_clearCount;
            w_wrData  = 32'h0000_0000;
            w_wrLanes = 4'b1111;
        end else if (w_doWrite) begin
            w_wrLanes = w_stLanes;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_wrLanes[i]) begin
                r_mem[w_wrIdx][8*i +: 8] <= w_wrData[8*i +: 8];
            end
        end
    end

    // The array read is non-blocking alongside the write, so a same-edge
    // read and write to one word returns the old contents. Only valid loads
    // update these registers, which keeps read_data steady otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ldWord     <= 32'h0000_0000;
            r_ldSize     <= SZ_BYTE;
            r_ldOffset   <= 2'b00;
            r_ldUnsigned <= 1'b0;
        end else if (w_doRead) begin
            r_ldWord     <= r_mem[w_wordIdx];
            r_ldSize     <= size;
            r_ldOffset   <= w_offset;
            r_ldUnsigned <= unsigned_ld;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_fault;
        end
    end

    assign read_data = w_ldData;
    assign ready     = (r_state == ST_RUN);
    assign misalign  = r_misalign;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// ---------------------------------------------------------------------------
// tb_data_memory_bytelane
// Directed bench for data_memory_bytelane using a 4-word array (ADDR_W=4).
// A second instance without the clear sequence checks immediate readiness.
// ---------------------------------------------------------------------------
module tb_data_memory_bytelane;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [3:0]  address = 4'h0;
    logic [1:0]  size = SZ_WORD;
    logic        unsignedLd = 1'b0;
    logic [31:0] writeData = 32'h0;
    logic [31:0] readData;
    logic        ready;
    logic        misalign;
    logic [31:0] readData2;
    logic        ready2;
    logic        misalign2;

    int assertCount = 0;
    int failCount   = 0;
    int cycles;

    always #5 clk = ~clk;

    data_memory_bytelane #(.ADDR_W(4), .CLEAR_ON_RESET(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .memread     (memread),
        .memwrite    (memwrite),
        .address     (address),
        .size        (size),
        .unsigned_ld (unsignedLd),
        .write_data  (writeData),
        .read_data   (readData),
        .ready       (ready),
        .misalign    (misalign)
    );

    data_memory_bytelane #(.ADDR_W(4), .CLEAR_ON_RESET(1'b0)) dutNoClear (
        .clk         (clk),
        .rst         (rst),
        .memread     (memread),
        .memwrite    (memwrite),
        .address     (address),
        .size        (size),
        .unsigned_ld (unsignedLd),
        .write_data  (writeData),
        .read_data   (readData2),
        .ready       (ready2),
        .misalign    (misalign2)
    );

    // Every comparison goes through here so the counters stay in one place.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    // Drive one access for exactly one rising edge, then return to idle.
    // On return the outputs reflect that edge.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [3:0] addr,
                                 input logic [1:0] sz, input logic uns,
                                 input logic [31:0] wdata);
        memread    = rd;
        memwrite   = wr;
        address    = addr;
        size       = sz;
        unsignedLd = uns;
        writeData  = wdata;
        @(posedge clk);
        #1;
        memread  = 1'b0;
        memwrite = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Count edges until ready rises, bounded so a stuck FSM cannot hang.
    task automatic waitReady(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        $display("[TB] Starting data_memory_bytelane directed test");

        // Reset and clear sequence
        pulseReset();
        checkOutput("reset_ready", {31'b0, ready}, 32'd0);
        checkOutput("reset_read_data", readData, 32'h0);
        checkOutput("reset_misalign", {31'b0, misalign}, 32'd0);
        checkOutput("noclear_ready", {31'b0, ready2}, 32'd1);
        checkOutput("noclear_read_data", readData2, 32'h0);
        waitReady(cycles);
        checkOutput("clear_cycles", cycles, 32'd4);

        applyStimulus(1'b1, 1'b0, 4'h0, SZ_WORD, 1'b0, 32'h0);
        checkOutput("clear_lw_0", readData, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'h4, SZ_WORD, 1'b0, 32'h0);
        checkOutput("clear_lw_4", readData, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'h8, SZ_WORD, 1'b0, 32'h0);
        checkOutput("clear_lw_8", readData, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'hC, SZ_WORD, 1'b0, 32'h0);
        checkOutput("clear_lw_c", readData, 32'h0);

        // Byte and half loads with sign/zero extension
        applyStimulus(1'b0, 1'b1, 4'h0, SZ_WORD, 1'b0, 32'h89AB_CDEF);
        checkOutput("sw_misalign", {31'b0, misalign}, 32'd0);
        applyStimulus(1'b1, 1'b0, 4'h0, SZ_BYTE, 1'b0, 32'h0);
        checkOutput("lb_0", readData, 32'hFFFF_FF89);
        applyStimulus(1'b1, 1'b0, 4'h0, SZ_BYTE, 1'b1, 32'h0);
        checkOutput("lbu_0", readData, 32'h0000_0089);
        applyStimulus(1'b1, 1'b0, 4'h3, SZ_BYTE, 1'b0, 32'h0);
        checkOutput("lb_3", readData, 32'hFFFF_FFEF);
        applyStimulus(1'b1, 1'b0, 4'h1, SZ_BYTE, 1'b0, 32'h0);
        checkOutput("lb_1", readData, 32'hFFFF_FFAB);
        applyStimulus(1'b1, 1'b0, 4'h2, SZ_BYTE, 1'b1, 32'h0);
        checkOutput("lbu_2", readData, 32'h0000_00CD);
        applyStimulus(1'b1, 1'b0, 4'h2, SZ_HALF, 1'b0, 32'h0);
        checkOutput("lh_2", readData, 32'hFFFF_CDEF);
        applyStimulus(1'b1, 1'b0, 4'h2, SZ_HALF, 1'b1, 32'h0);
        checkOutput("lhu_2", readData, 32'h0000_CDEF);
        applyStimulus(1'b1, 1'b0, 4'h0, SZ_HALF, 1'b0, 32'h0);
        checkOutput("lh_0", readData, 32'hFFFF_89AB);
        idleCycle();
        checkOutput("read_hold_idle", readData, 32'hFFFF_89AB);

        // Partial stores leave other lanes untouched
        applyStimulus(1'b0, 1'b1, 4'h1, SZ_BYTE, 1'b0, 32'hAAAA_AA55);
        applyStimulus(1'b0, 1'b1, 4'h2, SZ_HALF, 1'b0, 32'hFFFF_1234);
        applyStimulus(1'b1, 1'b0, 4'h0, SZ_WORD, 1'b0, 32'h0);
        checkOutput("partial_lw_0", readData, 32'h8955_1234);

        // Faults: flag one cycle later, no write, read_data holds
        applyStimulus(1'b1, 1'b0, 4'h2, SZ_WORD, 1'b0, 32'h0);
        checkOutput("lw_2_misalign", {31'b0, misalign}, 32'd1);
        checkOutput("lw_2_hold", readData, 32'h8955_1234);
        idleCycle();
        checkOutput("fault_pulse_end", {31'b0, misalign}, 32'd0);
        applyStimulus(1'b0, 1'b1, 4'h1, SZ_HALF, 1'b0, 32'h0000_BEEF);
        checkOutput("sh_1_misalign", {31'b0, misalign}, 32'd1);
        applyStimulus(1'b0, 1'b1, 4'h0, SZ_ILL, 1'b0, 32'hFFFF_FFFF);
        checkOutput("size11_wr_misalign", {31'b0, misalign}, 32'd1);
        applyStimulus(1'b1, 1'b0, 4'h0, SZ_ILL, 1'b0, 32'h0);
        checkOutput("size11_rd_misalign", {31'b0, misalign}, 32'd1);
        checkOutput("size11_rd_hold", readData, 32'h8955_1234);
        applyStimulus(1'b1, 1'b0, 4'h0, SZ_WORD, 1'b0, 32'h0);
        checkOutput("fault_mem_unchanged", readData, 32'h8955_1234);
        checkOutput("valid_clears_misalign", {31'b0, misalign}, 32'd0);

        // Read-during-write returns the old word
        applyStimulus(1'b1, 1'b1, 4'h0, SZ_WORD, 1'b0, 32'hDEAD_BEEF);
        checkOutput("rdw_old_data", readData, 32'h8955_1234);
        applyStimulus(1'b1, 1'b0, 4'h0, SZ_WORD, 1'b0, 32'h0);
        checkOutput("rdw_new_data", readData, 32'hDEAD_BEEF);

        // Another word, positive half
        applyStimulus(1'b0, 1'b1, 4'h4, SZ_WORD, 1'b0, 32'h1122_3344);
        applyStimulus(1'b1, 1'b0, 4'h6, SZ_HALF, 1'b0, 32'h0);
        checkOutput("lh_6", readData, 32'h0000_3344);
        applyStimulus(1'b1, 1'b0, 4'h0, SZ_WORD, 1'b0, 32'h0);
        checkOutput("word0_intact", readData, 32'hDEAD_BEEF);

        // Reset in the middle of clearing restarts the full sequence
        applyStimulus(1'b0, 1'b1, 4'h8, SZ_WORD, 1'b0, 32'hCAFE_F00D);
        applyStimulus(1'b0, 1'b1, 4'hC, SZ_WORD, 1'b0, 32'h0BAD_BEEF);
        pulseReset();
        idleCycle();
        idleCycle();
        pulseReset();
        checkOutput("midclear_ready", {31'b0, ready}, 32'd0);
        checkOutput("midclear_read_data", readData, 32'h0);
        waitReady(cycles);
        checkOutput("midclear_cycles", cycles, 32'd4);
        applyStimulus(1'b1, 1'b0, 4'h0, SZ_WORD, 1'b0, 32'h0);
        checkOutput("midclear_lw_0", readData, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'h4, SZ_WORD, 1'b0, 32'h0);
        checkOutput("midclear_lw_4", readData, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'h8, SZ_WORD, 1'b0, 32'h0);
        checkOutput("midclear_lw_8", readData, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'hC, SZ_WORD, 1'b0, 32'h0);
        checkOutput("midclear_lw_c", readData, 32'h0);
        checkOutput("midclear_misalign", {31'b0, misalign}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/data_memory_bytelane.md
Name: data_memory_bytelane

Overview:
Parametrised next-generation MIPS data memory with byte-addressed, size-aware loads and stores.
- Stores: sb/sh/sw via big-endian byte lanes. Loads: lb/lbu/lh/lhu/lw with sign or zero extension.
- Flags misaligned and illegal-size accesses.
- Optional post-reset clear sequencer zeroes the array before the pipeline may access it.
- Sits in the MEM stage between the ALU result and the write-back mux.

Parameters:
ADDR_W, 15, byte-address width; word count WORDS = 2**(ADDR_W-2), so 8192 words by default.
CLEAR_ON_RESET, 1, 1 = zero every word after reset before asserting ready; 0 = ready immediately, contents undefined.

Ports:
clk  input  1  system clock, all activity on rising edge
rst  input  1  synchronous active-high reset
memread  input  1  load request, sampled at posedge
memwrite  input  1  store request, sampled at posedge
address  input  ADDR_W  byte address; [ADDR_W-1:2] word index, [1:0] byte offset
size  input  2  00 byte, 01 half, 10 word, 11 illegal
unsigned_ld  input  1  1 = zero-extend byte/half loads (lbu/lhu)
write_data  input  32  store data, right-justified (sb uses [7:0], sh uses [15:0])
read_data  output  32  registered, extended load result
ready  output  1  1 = block accepts accesses
misalign  output  1  registered one-cycle fault pulse for the preceding access

Behaviour:
- Reset (rst=1 at posedge):
  - read_data=0, misalign=0, clear counter=0.
  - FSM enters CLEAR if CLEAR_ON_RESET=1 (ready=0), otherwise RUN (ready=1).
  - Reset asserted mid-CLEAR restarts the counter at 0.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle writes 0 to word[counter], then counter++. memread/memwrite are ignored; read_data and misalign hold 0.
  - After writing word WORDS-1, transition to RUN. ready=1 from the next cycle; CLEAR lasts exactly WORDS cycles.
  - RUN persists until rst.
- Alignment rules:
  - Half requires address[0]=0. Word requires address[1:0]=00. size=11 is always a fault.
  - Faulting access: no array write; read_data holds its previous value; misalign=1 for one cycle after the access edge.
  - A valid access, or no access, clears misalign to 0.
- Store, RUN, memwrite=1, aligned (big-endian lanes, offset 0 = bits [31:24]):
  - Byte: lane 3-offset gets write_data[7:0].
  - Half: offset 0 writes [31:16], offset 2 writes [15:0], from write_data[15:0].
  - Word: full write.
  - Write takes effect at the posedge; unwritten lanes are untouched.
- Load, RUN, memread=1, aligned:
  - Latency 1: read_data is valid the cycle after the request edge.
  - Lane select and extension use the registered offset, size and unsigned_ld.
  - read_data holds when memread=0.
- memread and memwrite together at the same word: the read returns pre-write data (read-before-write); the write still occurs.
- No out-of-range case; ADDR_W exactly covers the array.

Decomposition:
- Package mem_pkg:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_ILL=2'b11.
  - FSM state typedef {ST_CLEAR, ST_RUN}.
  - Function is_aligned(size, offset).
- Sub-module mem_lane_align (combinational), instantiated twice:
  - Store side: produces the 4-bit lane enable and shifted write word.
  - Load side: produces the selected, extended read word.
- Top module holds the array, FSM, clear counter and output registers.

Test Plan:
- Clear sequence (ADDR_W=4, CLEAR_ON_RESET=1): pulse rst, then hold idle -> ready=0 for exactly 4 cycles, then 1; lw at 0x0,0x4,0x8,0xC returns 0x00000000.
- Byte/half loads: sw 0x89ABCDEF at 0x0, then loads:
  - lb 0x0 -> 0xFFFFFF89
  - lbu 0x0 -> 0x00000089
  - lb 0x3 -> 0xFFFFFFEF
  - lh 0x2 -> 0xFFFFCDEF
  - lhu 0x2 -> 0x0000CDEF
  - each result one cycle after its request.
- Partial stores: sb 0x55 at 0x1, then sh 0x1234 at 0x2 -> lw 0x0 returns 0x89551234.
- Faults: lw at 0x2, sh at 0x1, size=11 at 0x0 -> misalign=1 the cycle after each; memory unchanged (lw 0x0 = 0x89551234); read_data holds its prior value.
- Read-during-write: memread+memwrite sw 0xDEADBEEF at 0x0 -> read_data=0x89551234; a following lw returns 0xDEADBEEF.
- Reset mid-clear (ADDR_W=4): rst at clear cycle 2 -> ready stays 0 for 4 further cycles; all words read 0.
